// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master drives run and the operands; the slave (the divider) returns results and status.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             run;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             busy;
  logic             dbz;

  modport master (
    output run, dividend, divisor,
    input  quotient, remainder, ready, busy, dbz
  );

  modport slave (
    input  run, dividend, divisor,
    output quotient, remainder, ready, busy, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per CALC cycle, WIDTH cycles per operation.
// Optional `SEQ_DIVIDER_DBZ_EN: a zero divisor finishes after one cycle with dbz set.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] hi, lo, dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             ready_r, busy_r, dbz_r;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic             last, dbz_cut;

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIVIDER_DBZ_EN
  assign dbz_cut = (state == CALC) && (dvsr == '0);
`else
  assign dbz_cut = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.run)         next_state = CALC;
      CALC:    if (last || dbz_cut) next_state = DONE;
      DONE:    if (!bus.run)        next_state = IDLE;
      default:                      next_state = IDLE;
    endcase
  end

  // One restoring step; the shifted-out MSB of hi is kept as bit WIDTH of the trial
  // so divisors with their top bit set still compare correctly.
  always_comb begin
    trial   = {hi, lo[WIDTH-1]} - {1'b0, dvsr};
    lo_step = {lo[WIDTH-2:0], ~trial[WIDTH]};
    hi_step = trial[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : trial[WIDTH-1:0];
  end

  // Datapath and registered outputs; results are only written on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.run) begin
          hi     <= '0;
          lo     <= bus.dividend;
          dvsr   <= bus.divisor;
          cnt    <= '0;
          busy_r <= 1'b1;
          dbz_r  <= 1'b0;
        end
        CALC: begin
          if (dbz_cut) begin
            quotient_r  <= '1;
            remainder_r <= lo;
            dbz_r       <= 1'b1;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            cnt         <= '0;
          end else begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
              quotient_r  <= lo_step;
              remainder_r <= hi_step;
              busy_r      <= 1'b0;
              ready_r     <= 1'b1;
            end
          end
        end
        DONE: if (!bus.run) ready_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.dbz       = dbz_r;
endmodule
